// File: rtl/alu_md_control.sv
`timescale 1ns/1ps
// alu_md_control: EX-stage ALU control decoder with an iterative RV32M sequencer.
//   Base decode maps aluOp/funct3/funct7 to the 5-bit ALU operation code.
//   R-type encodings with funct7 == 7'b0000001 decode to the M codes 17..24 and
//   launch a radix-2 shift-add multiply or restoring divide. Stall is held while
//   the sequencer runs; mdDone pulses in the cycle mdResult becomes valid.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   aluOp             operation class from the main decoder
//   funct3, funct7    instruction function fields
//   valid, flush      live instruction in EX / pipeline kill
//   opA, opB          rs1 / rs2 operands
//   aluControl        ALU operation code (combinational)
//   stall             hold EX and upstream stages
//   mdDone, mdResult  one-cycle completion pulse / M-op result
module alu_md_control #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      aluOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic [4:0]      aluControl,
  output logic            stall,
  output logic            mdDone,
  output logic [XLEN-1:0] mdResult
);

  // Operation classes from the main decoder.
  localparam logic [3:0] ALU_OP_ADD     = 4'd0;
  localparam logic [3:0] ALU_OP_R       = 4'd1;
  localparam logic [3:0] ALU_OP_I_ARITH = 4'd2;
  localparam logic [3:0] ALU_OP_B       = 4'd3;
  localparam logic [3:0] ALU_OP_LUI     = 4'd4;

  // Base ALU operation codes.
  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_BEQ = 5'd10, ALU_BNE = 5'd11;
  localparam logic [4:0] ALU_BLT = 5'd12, ALU_BGE = 5'd13, ALU_BLTU = 5'd14, ALU_BGEU = 5'd15;
  localparam logic [4:0] ALU_PASSB = 5'd16, ALU_MUL = 5'd17;

  localparam int unsigned     CW      = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CntLast = CW'(XLEN);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;   // mul: product hi/lo; div: remainder/quotient
  logic [XLEN-1:0]   opnd_q, opnd_d;           // mul: |multiplicand|; div: |divisor|
  logic [2:0]        op_q, op_d;
  logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_m, md_start, sign_a, sign_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  assign is_m = (aluOp == ALU_OP_R) && (funct7 == 7'b0000001);

  always_comb begin
    aluControl = ALU_ADD;
    if (ENABLE_M && is_m) begin
      aluControl = ALU_MUL + {2'b00, funct3};
    end else begin
      unique case (aluOp)
        ALU_OP_R, ALU_OP_I_ARITH: begin
          unique case (funct3)
            3'b000: aluControl = (aluOp == ALU_OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: aluControl = ALU_SLL;
            3'b010: aluControl = ALU_SLT;
            3'b011: aluControl = ALU_SLTU;
            3'b100: aluControl = ALU_XOR;
            3'b101: aluControl = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: aluControl = ALU_OR;
            default: aluControl = ALU_AND;
          endcase
        end
        ALU_OP_B: begin
          unique case (funct3)
            3'b000:  aluControl = ALU_BEQ;
            3'b001:  aluControl = ALU_BNE;
            3'b100:  aluControl = ALU_BLT;
            3'b101:  aluControl = ALU_BGE;
            3'b110:  aluControl = ALU_BLTU;
            3'b111:  aluControl = ALU_BGEU;
            default: aluControl = ALU_ADD;
          endcase
        end
        ALU_OP_LUI: aluControl = ALU_PASSB;
        default:    aluControl = ALU_ADD;
      endcase
    end
  end

  // rst gating keeps stall low while reset is asserted.
  assign md_start = ENABLE_M && rst && valid && is_m && (state_q == StIdle) && !flush;
  assign stall    = rst && !flush && (md_start || (state_q != StIdle && state_q != StDone));
  assign mdDone   = rst && !flush && (state_q == StDone);
  assign mdResult = result_q;

  // MUL, MULH, MULHSU, DIV, REM take opA as signed; MULHSU keeps opB unsigned.
  assign sign_a = opA[XLEN-1] && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
  assign sign_b = opB[XLEN-1] && (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
  assign a_mag  = sign_a ? -opA : opA;
  assign b_mag  = sign_b ? -opB : opB;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    prod      = '0;
    quo       = '0;
    rem       = '0;
    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          op_d      = funct3;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = '0;
          hi_d      = '0;
          if (!funct3[2]) begin
            opnd_d  = a_mag;
            lo_d    = b_mag;
            state_d = StMul;
          end else if (opB == '0) begin
            result_d = funct3[1] ? opA : '1;
            state_d  = StDone;
          end else if (!funct3[0] && opA == MinNeg && opB == '1) begin
            result_d = funct3[1] ? '0 : opA;
            state_d  = StDone;
          end else begin
            opnd_d  = b_mag;
            lo_d    = a_mag;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        mul_sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
        cnt_d        = cnt_q + 1'b1;
        if (cnt_d == CntLast) state_d = StFix;
      end
      StDiv: begin
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[XLEN]) begin
          hi_d = div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CntLast) state_d = StFix;
      end
      StFix: begin
        if (!op_q[2]) begin
          prod     = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};
          result_d = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
          quo      = neg_res_q ? -lo_q : lo_q;
          rem      = neg_rem_q ? -hi_q : hi_q;
          result_d = op_q[1] ? rem : quo;
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_md_control.sv
`timescale 1ns/1ps
module tb_alu_md_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  aluOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        valid, flush;
  logic [31:0] opA, opB;
  logic [4:0]  ctrl, nom_ctrl;
  logic        stall, nom_stall, done, nom_done;
  logic [31:0] result, nom_result;

  int  n_tests = 0;
  int  n_fail  = 0;
  time done_time;

  always #5 clk = ~clk;

  alu_md_control #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (
    .clk(clk), .rst(rst), .aluOp(aluOp), .funct3(funct3), .funct7(funct7),
    .valid(valid), .flush(flush), .opA(opA), .opB(opB),
    .aluControl(ctrl), .stall(stall), .mdDone(done), .mdResult(result)
  );

  alu_md_control #(.XLEN(32), .ENABLE_M(1'b0)) u_nom (
    .clk(clk), .rst(rst), .aluOp(aluOp), .funct3(funct3), .funct7(funct7),
    .valid(valid), .flush(flush), .opA(opA), .opB(opB),
    .aluControl(nom_ctrl), .stall(nom_stall), .mdDone(nom_done), .mdResult(nom_result)
  );

  // Base R-type codes for funct7 == 0: ADD SLL SLT SLTU XOR SRL OR AND.
  logic [4:0] base_r [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, ub, ps;
    longint unsigned pu;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    pu = {32'h0, a} * {32'h0, b};
    case (f3)
      3'd0: begin ps = sa * sb; r = ps[31:0]; end
      3'd1: begin ps = sa * sb; r = ps[63:32]; end
      3'd2: begin ps = sa * ub; r = ps[63:32]; end
      3'd3: r = pu[63:32];
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin ps = sa / sb; r = ps[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin ps = sa % sb; r = ps[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Issues one M op starting at the next negedge and waits for its completion.
  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    logic [31:0] exp_res;
    int          exp_lat, lat;
    bit          seen;
    exp_res = ref_md(f3, a, b);
    exp_lat = ref_lat(f3, a, b);
    @(negedge clk);
    aluOp = 4'd1; funct7 = 7'b0000001; funct3 = f3; opA = a; opB = b; valid = 1'b1;
    #1;
    n_tests++;
    if (ctrl !== 5'd17 + {2'b00, f3} || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: ctrl=%0d stall=%b, required ctrl=%0d stall=1",
               name, ctrl, stall, 5'd17 + {2'b00, f3});
    end
    n_tests++;
    if (nom_stall !== 1'b0 || nom_ctrl !== base_r[f3]) begin
      n_fail++;
      $display("FAIL %s nom: ctrl=%0d stall=%b, required ctrl=%0d stall=0",
               name, nom_ctrl, nom_stall, base_r[f3]);
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        valid = 1'b0; funct3 = 3'($urandom); opA = $urandom; opB = $urandom;
      end
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    done_time = $time;
    n_tests++;
    if (!seen || lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: seen=%b got=%0d, required %0d", name, seen, lat, exp_lat);
    end
    n_tests++;
    if (result !== exp_res || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: got=%h stall=%b, required %h stall=0",
               name, result, stall, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b1; flush = 1'b0;
    aluOp = 4'd1; funct7 = 7'b0000001; funct3 = 3'd0; opA = 32'd5; opB = 32'd6;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: stall=%b done=%b result=%h, required 0/0/0", stall, done, result);
    end
    valid = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset: stall=%b done=%b result=%h, required 0/0/0",
               stall, done, result);
    end
  endtask

  task automatic test_base_decode();
    // {aluOp, funct3, funct7, expected code}
    logic [18:0] vec [10] = '{
      {4'd1, 3'b000, 7'b0000000, 5'd0},   // ADD
      {4'd1, 3'b000, 7'b0100000, 5'd1},   // SUB
      {4'd1, 3'b101, 7'b0100000, 5'd7},   // SRA
      {4'd1, 3'b101, 7'b0000000, 5'd6},   // SRL
      {4'd2, 3'b010, 7'b0000000, 5'd3},   // SLTI
      {4'd2, 3'b000, 7'b0100000, 5'd0},   // ADDI with imm bit set
      {4'd2, 3'b000, 7'b0000001, 5'd0},   // not R class, so not M
      {4'd3, 3'b100, 7'b0000000, 5'd12},  // BLT
      {4'd3, 3'b000, 7'b0000000, 5'd10},  // BEQ
      {4'd4, 3'b011, 7'b0000000, 5'd16}   // LUI
    };
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      {aluOp, funct3, funct7} = vec[i][18:5];
      opA = $urandom; opB = $urandom; valid = 1'b1;
      #1;
      n_tests++;
      if (ctrl !== vec[i][4:0] || nom_ctrl !== vec[i][4:0] || stall !== 1'b0 ||
          nom_stall !== 1'b0) begin
        n_fail++;
        $display("FAIL base_decode[%0d]: ctrl=%0d nom=%0d stall=%b/%b, required %0d stall=0",
                 i, ctrl, nom_ctrl, stall, nom_stall, vec[i][4:0]);
      end
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_m_decode();
    for (int f = 0; f < 8; f++) begin
      @(negedge clk);
      aluOp = 4'd1; funct7 = 7'b0000001; funct3 = 3'(f); valid = 1'b0;
      #1;
      n_tests++;
      if (ctrl !== 5'(17 + f) || nom_ctrl !== base_r[f] || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL m_decode[%0d]: ctrl=%0d nom=%0d stall=%b, required %0d nom=%0d stall=0",
                 f, ctrl, nom_ctrl, stall, 17 + f, base_r[f]);
      end
    end
  endtask

  task automatic test_directed();
    run_md(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ones");
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ones");
    run_md(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "mulhsu");
    run_md(3'd5, 32'd100, 32'd7, "divu_100_7");
    run_md(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_md(3'd4, 32'h1234_5678, 32'h0, "div_by_0");
    run_md(3'd7, 32'h1234_5678, 32'h0, "remu_by_0");
    run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    run_md(3'd4, 32'h8000_0000, 32'd2, "div_min_2");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = $urandom_range(1, 9);
        default: ;
      endcase
      run_md(3'($urandom), a, b, "random");
    end
  endtask

  task automatic test_flush();
    bit seen;
    run_md(3'd5, 32'd100, 32'd7, "flush_prep");
    @(negedge clk);
    aluOp = 4'd1; funct7 = 7'b0000001; funct3 = 3'd4; opA = 32'd1000; opB = 32'd3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: stall=%b done=%b, required 0/0", stall, done);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: stall=%b, required 0", stall);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen || result !== 32'd14) begin
      n_fail++;
      $display("FAIL flush_after: done_seen=%b result=%h, required 0 and 0000000e", seen, result);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    run_md(3'd0, 32'd7, 32'hFFFF_FFFD, "rstmid_prep");
    @(negedge clk);
    aluOp = 4'd1; funct7 = 7'b0000001; funct3 = 3'd3; opA = 32'hDEAD_BEEF; opB = 32'h1234;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_cycle: stall=%b done=%b, required 0/0", stall, done);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_after: stall=%b done=%b result=%h, required 0/0/0",
               stall, done, result);
    end
    rst  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1 || stall === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen || result !== 32'h0 || nom_result !== 32'h0 || nom_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: activity=%b result=%h nom=%h, required 0 and 0",
               seen, result, nom_result);
    end
  endtask

  task automatic test_back_to_back();
    time t1;
    run_md(3'd0, 32'h0001_2345, 32'hFFFF_0003, "b2b_first");
    t1 = done_time;
    run_md(3'd0, 32'h8765_4321, 32'h0000_0777, "b2b_second");
    n_tests++;
    if (done_time - t1 != 350) begin
      n_fail++;
      $display("FAIL b2b_spacing: got=%0d ns, required 350 ns", done_time - t1);
    end
  endtask

  initial begin
    test_reset();
    test_base_decode();
    test_m_decode();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
